minterm_sweeper: RTL and testbench
==================================

MINTERM_SWEEPER -- requirements
Module: minterm_sweeper

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SETTLE, 1, cycles {x,y,z} is held before sampling; legal range 1..15.
- EXPECTED, 8'hC5, golden minterm mask, bit i = f(i); default is m(0,2,6,7).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a sweep; honoured only in IDLE.
- x, out, 1, MSB of minterm index driven to both functions under test.
- y, out, 1, middle bit of minterm index.
- z, out, 1, LSB of minterm index.
- s1, in, 1, output of first implementation.
- s2, in, 1, output of second implementation.
- busy, out, 1, high in SETTLE and SAMPLE.
- done, out, 1, one-cycle pulse, high in the DONE state.
- tt1, out, 8, captured truth table of s1; bit i = s1 at minterm i.
- tt2, out, 8, captured truth table of s2.
- equal, out, 1, tt1==tt2; registered on entry to DONE.
- match_exp, out, 1, tt1==EXPECTED && tt2==EXPECTED; registered on entry to DONE.
- first_diff, out, 3, lowest i with tt1[i]!=tt2[i]; 0 when equal.
REQ-003 Clock is clk, single domain; reset is rst_n, asynchronous, active-low.

Function
REQ-004 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-005 IDLE transition: start=1 at an edge -> SETTLE; idx<=0, settle counter<=0, tt1<=0, tt2<=0.
REQ-006 IDLE with start=0: hold state; tt1, tt2, equal, match_exp, first_diff keep their last values.
REQ-007 {x,y,z} SHALL be registered and equal idx at all times; x is the MSB.
REQ-008 SETTLE transition: counter==SETTLE-1 -> SAMPLE; otherwise counter increments.
REQ-009 SAMPLE edge: tt1[idx]<=s1 and tt2[idx]<=s2, sampled as presented with no filtering.
REQ-010 SAMPLE, idx!=7: idx increments, counter<=0, next state SETTLE.
REQ-011 SAMPLE, idx==7: next state DONE; idx holds 7; equal, match_exp and first_diff are computed from the final tables, including the bit captured on that edge.
REQ-012 DONE lasts exactly one cycle with done=1, then returns to IDLE; {x,y,z} returns to 0 on that edge.
REQ-013 Latency: done is high in the cycle after the edge that is 8*(SETTLE+1) edges past the accepting start edge (16 for SETTLE=1).
REQ-014 start while busy or in DONE SHALL be ignored, with no restart or extension.
REQ-015 start held high continuously SHALL begin a new sweep on the first IDLE edge after DONE.
REQ-016 first_diff uses lowest-index priority; equal=1 forces first_diff=0.

Reset
REQ-017 rst_n low SHALL immediately force IDLE, including mid-sweep, and clear idx and the counter.
REQ-018 Reset values: x=y=z=0, busy=0, done=0, tt1=tt2=8'h00, equal=0, match_exp=0, first_diff=0.
REQ-019 After rst_n deasserts, the first sweep requires a fresh start; no partial results survive.

Structure
REQ-020 A shared package sweeper_pkg SHALL hold the state enum, MINTERM_W=3, TT_W=8 and the default EXPECTED constant.
REQ-021 A single sub-module prio_enc8 SHALL map an 8-bit mismatch vector (tt1^tt2) to the lowest set index plus a none-flag.
REQ-022 No other hierarchy; the counter, idx and FSM stay in minterm_sweeper.

Verification
REQ-023 Both s1 and s2 driven by the m(0,2,6,7) function, SETTLE=1: start pulse -> done at edge 16; tt1=tt2=8'hC5; equal=1; match_exp=1; first_diff=0.
REQ-024 s2 forced wrong at minterm 3 only: tt1=8'hC5, tt2=8'hCD, equal=0, match_exp=0, first_diff=3.
REQ-025 SETTLE=3: done at edge 32 after start; {x,y,z} holds each value for exactly 4 cycles, sequencing 000..111.
REQ-026 rst_n pulsed low while idx=4: all outputs take reset values asynchronously; a restart then yields a full 8'hC5 sweep.
REQ-027 start re-pulsed at idx=2 and during DONE: no effect; exactly one done pulse, and final results match REQ-023.
REQ-028 Bench checks done is a single-cycle pulse and busy=0 in IDLE and DONE throughout all scenarios.

Source files
------------

// File: rtl/sweeper_pkg.sv
// Shared types and constants for the minterm sweeper: FSM states, table
// widths and the default golden truth table.
package sweeper_pkg;

  localparam int unsigned MINTERM_W = 3;
  localparam int unsigned TT_W      = 8;
  localparam int unsigned CNT_W     = 4;

  // m(0,2,6,7): bit i of the mask is f(i)
  localparam logic [TT_W-1:0] EXPECTED_DEFAULT = 8'hC5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-index priority encoder over an 8-bit vector; none=1 when no bit is set.
module prio_enc8
  import sweeper_pkg::*;
(
  input  logic [TT_W-1:0]      vec,
  output logic [MINTERM_W-1:0] idx,
  output logic                 none
);

  // Bit 0 wins over every higher bit.
  always_comb begin
    idx  = 3'd0;
    none = 1'b0;
    casez (vec)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default: begin
        idx  = 3'd0;
        none = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/minterm_sweeper.sv
// Walks {x,y,z} through all eight minterms, captures the truth tables of two
// implementations and reports equality, golden match and the first mismatch.
module minterm_sweeper
  import sweeper_pkg::*;
#(
  parameter int unsigned     SETTLE   = 1,
  parameter logic [TT_W-1:0] EXPECTED = EXPECTED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 x,
  output logic                 y,
  output logic                 z,
  input  logic                 s1,
  input  logic                 s2,
  output logic                 busy,
  output logic                 done,
  output logic [TT_W-1:0]      tt1,
  output logic [TT_W-1:0]      tt2,
  output logic                 equal,
  output logic                 match_exp,
  output logic [MINTERM_W-1:0] first_diff
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 32'd1);

  state_e               state_r, state_next_s;
  logic [MINTERM_W-1:0] idx_r, idx_next_s;
  logic [CNT_W-1:0]     cnt_r, cnt_next_s;
  logic [TT_W-1:0]      tt1_r, tt1_next_s;
  logic [TT_W-1:0]      tt2_r, tt2_next_s;
  logic                 finish_s;
  logic                 equal_r, match_r, busy_r, done_r;
  logic [MINTERM_W-1:0] first_diff_r;
  logic [MINTERM_W-1:0] diff_idx_s;
  logic                 diff_none_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state plus next index/counter/tables for the sweep.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    cnt_next_s   = cnt_r;
    tt1_next_s   = tt1_r;
    tt2_next_s   = tt2_r;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_SETTLE;
          idx_next_s   = 3'd0;
          cnt_next_s   = 4'd0;
          tt1_next_s   = 8'h00;
          tt2_next_s   = 8'h00;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_next_s = ST_SAMPLE;
        end else begin
          cnt_next_s = cnt_r + 4'd1;
        end
      end
      ST_SAMPLE: begin
        tt1_next_s[idx_r] = s1;
        tt2_next_s[idx_r] = s2;
        if (idx_r == 3'd7) begin
          state_next_s = ST_DONE;
          finish_s     = 1'b1;
        end else begin
          state_next_s = ST_SETTLE;
          idx_next_s   = idx_r + 3'd1;
          cnt_next_s   = 4'd0;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
        idx_next_s   = 3'd0;
      end
      default: begin
        state_next_s = ST_IDLE;
        idx_next_s   = 3'd0;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Mismatch search runs on the tables as they will stand after this edge.
  prio_enc8 u_prio_enc8 (
    .vec  (tt1_next_s ^ tt2_next_s),
    .idx  (diff_idx_s),
    .none (diff_none_s)
  );

  // Datapath registers; verdicts only move on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r        <= 3'd0;
      cnt_r        <= 4'd0;
      tt1_r        <= 8'h00;
      tt2_r        <= 8'h00;
      equal_r      <= 1'b0;
      match_r      <= 1'b0;
      first_diff_r <= 3'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      idx_r  <= idx_next_s;
      cnt_r  <= cnt_next_s;
      tt1_r  <= tt1_next_s;
      tt2_r  <= tt2_next_s;
      busy_r <= (state_next_s == ST_SETTLE) || (state_next_s == ST_SAMPLE);
      done_r <= (state_next_s == ST_DONE);
      if (finish_s) begin
        equal_r      <= diff_none_s;
        match_r      <= (tt1_next_s == EXPECTED) && (tt2_next_s == EXPECTED);
        first_diff_r <= diff_none_s ? 3'd0 : diff_idx_s;
      end else begin
        equal_r      <= equal_r;
        match_r      <= match_r;
        first_diff_r <= first_diff_r;
      end
    end
  end

  assign {x, y, z}  = idx_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign tt1        = tt1_r;
  assign tt2        = tt2_r;
  assign equal      = equal_r;
  assign match_exp  = match_r;
  assign first_diff = first_diff_r;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Self-checking bench: two sweepers (SETTLE=1 and SETTLE=3) against a
// cycle-count based model of the sweep, plus directed literal checks.
module tb_minterm_sweeper;

  logic            clk;
  logic            rst_n;
  logic [1:0]      start_v;
  logic [1:0]      x_w, y_w, z_w, s1_w, s2_w, busy_w, done_w, equal_w, match_w;
  logic [1:0][7:0] tt1_w, tt2_w;
  logic [1:0][2:0] fd_w;
  logic [7:0]      fm1 [2];
  logic [7:0]      fm2 [2];

  int total = 0;
  int bad   = 0;

  // model state per DUT
  int         sv    [2] = '{1, 3};
  bit         act   [2];
  int         j     [2];
  logic [7:0] sf1   [2];
  logic [7:0] sf2   [2];
  logic [7:0] held1 [2];
  logic [7:0] held2 [2];
  int         m_eq  [2];
  int         m_mt  [2];
  int         m_fd  [2];

  assign s1_w[0] = fm1[0][{x_w[0], y_w[0], z_w[0]}];
  assign s2_w[0] = fm2[0][{x_w[0], y_w[0], z_w[0]}];
  assign s1_w[1] = fm1[1][{x_w[1], y_w[1], z_w[1]}];
  assign s2_w[1] = fm2[1][{x_w[1], y_w[1], z_w[1]}];

  minterm_sweeper #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .x(x_w[0]), .y(y_w[0]), .z(z_w[0]), .s1(s1_w[0]), .s2(s2_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .tt1(tt1_w[0]), .tt2(tt2_w[0]),
    .equal(equal_w[0]), .match_exp(match_w[0]), .first_diff(fd_w[0])
  );

  minterm_sweeper #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .x(x_w[1]), .y(y_w[1]), .z(z_w[1]), .s1(s1_w[1]), .s2(s2_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .tt1(tt1_w[1]), .tt2(tt2_w[1]),
    .equal(equal_w[1]), .match_exp(match_w[1]), .first_diff(fd_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act_v, input int exp_v);
    total++;
    if (act_v != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; j[d] = 0;
      held1[d] = 8'h00; held2[d] = 8'h00;
      m_eq[d] = 0; m_mt[d] = 0; m_fd[d] = 0;
    end
  endtask

  // One clock edge of the model: a sweep takes 8*(SETTLE+1) edges, then one DONE cycle.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int per = sv[d] + 1;
      if (act[d]) begin
        j[d]++;
        if (j[d] == 8 * per) begin
          held1[d] = sf1[d];
          held2[d] = sf2[d];
          m_eq[d]  = (sf1[d] == sf2[d]) ? 1 : 0;
          m_mt[d]  = (sf1[d] == 8'hC5 && sf2[d] == 8'hC5) ? 1 : 0;
          m_fd[d]  = 0;
          for (int i = 7; i >= 0; i--)
            if (sf1[d][i] != sf2[d][i]) m_fd[d] = i;
        end else if (j[d] > 8 * per) begin
          act[d] = 1'b0;
        end
      end else if (start_v[d]) begin
        act[d] = 1'b1;
        j[d]   = 0;
        sf1[d] = fm1[d];
        sf2[d] = fm2[d];
      end
    end
  endtask

  task automatic compare_dut(input int d);
    int per = sv[d] + 1;
    int n, lm, e_busy, e_done, e_idx, e_t1, e_t2;
    e_busy = (act[d] && j[d] < 8 * per) ? 1 : 0;
    e_done = (act[d] && j[d] == 8 * per) ? 1 : 0;
    e_idx  = !act[d] ? 0 : (j[d] < 8 * per) ? j[d] / per : 7;
    n      = (j[d] / per > 8) ? 8 : j[d] / per;
    lm     = (1 << n) - 1;
    e_t1   = act[d] ? int'(sf1[d]) & lm : int'(held1[d]);
    e_t2   = act[d] ? int'(sf2[d]) & lm : int'(held2[d]);
    check($sformatf("d%0d_busy", d), int'(busy_w[d]), e_busy);
    check($sformatf("d%0d_done", d), int'(done_w[d]), e_done);
    check($sformatf("d%0d_xyz", d), int'({x_w[d], y_w[d], z_w[d]}), e_idx);
    check($sformatf("d%0d_tt1", d), int'(tt1_w[d]), e_t1);
    check($sformatf("d%0d_tt2", d), int'(tt2_w[d]), e_t2);
    check($sformatf("d%0d_equal", d), int'(equal_w[d]), m_eq[d]);
    check($sformatf("d%0d_match", d), int'(match_w[d]), m_mt[d]);
    check($sformatf("d%0d_fdiff", d), int'(fd_w[d]), m_fd[d]);
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) compare_dut(d);
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_v = 2'b00;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_xyz", d), int'({x_w[d], y_w[d], z_w[d]}), 0);
      check($sformatf("rst%0d_busy", d), int'(busy_w[d]), 0);
      check($sformatf("rst%0d_done", d), int'(done_w[d]), 0);
      check($sformatf("rst%0d_tt", d), int'({tt1_w[d], tt2_w[d]}), 0);
      check($sformatf("rst%0d_verdict", d), int'({equal_w[d], match_w[d], fd_w[d]}), 0);
    end
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Full sweep on one DUT; returns edges from accepting start to the done cycle.
  task automatic sweep(input int d, input logic [7:0] m1, input logic [7:0] m2,
                       input bit repulse, output int edges);
    int  hist [8];
    int  dones = 0;
    bit  pulsed = 1'b0;
    bit  seen = 1'b0;
    for (int v = 0; v < 8; v++) hist[v] = 0;
    fm1[d] = m1;
    fm2[d] = m2;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    edges = 0;
    for (int k = 0; k < 300; k++) begin
      if (busy_w[d]) hist[{x_w[d], y_w[d], z_w[d]}]++;
      if (done_w[d]) begin
        seen = 1'b1;
        dones++;
        break;
      end
      start_v[d] = (repulse && !pulsed && {x_w[d], y_w[d], z_w[d]} == 3'd2);
      if (start_v[d]) pulsed = 1'b1;
      tick();
      edges++;
    end
    start_v[d] = 1'b0;
    check($sformatf("sweep%0d_done_seen", d), int'(seen), 1);
    for (int v = 0; v < 8; v++)
      check($sformatf("sweep%0d_hold_%0d", d, v), hist[v], sv[d] + 1);
    if (repulse) begin
      check("repulse_at_idx2", int'(pulsed), 1);
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      if (done_w[d]) dones++;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (done_w[d]) dones++;
      end
      check("repulse_done_count", dones, 1);
      check("repulse_busy_after", int'(busy_w[d]), 0);
    end
  endtask

  initial begin
    int edges;
    bit reached;
    rst_n   = 1'b0;
    start_v = 2'b00;
    fm1[0] = 8'hC5; fm2[0] = 8'hC5;
    fm1[1] = 8'hC5; fm2[1] = 8'hC5;
    model_reset();
    #1;
    check("init_busy", int'(busy_w), 0);
    check("init_tt1", int'(tt1_w), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // both implementations correct
    sweep(0, 8'hC5, 8'hC5, 1'b0, edges);
    check("basic_latency", edges, 16);
    check("basic_tt1", int'(tt1_w[0]), 32'hC5);
    check("basic_tt2", int'(tt2_w[0]), 32'hC5);
    check("basic_equal", int'(equal_w[0]), 1);
    check("basic_match", int'(match_w[0]), 1);
    check("basic_fdiff", int'(fd_w[0]), 0);
    tick();

    // second implementation wrong at minterm 3 only
    sweep(0, 8'hC5, 8'hCD, 1'b0, edges);
    check("m3_tt1", int'(tt1_w[0]), 32'hC5);
    check("m3_tt2", int'(tt2_w[0]), 32'hCD);
    check("m3_equal", int'(equal_w[0]), 0);
    check("m3_match", int'(match_w[0]), 0);
    check("m3_fdiff", int'(fd_w[0]), 3);
    tick();

    // longer settle time
    sweep(1, 8'hC5, 8'hC5, 1'b0, edges);
    check("settle3_latency", edges, 32);
    check("settle3_match", int'(match_w[1]), 1);
    tick();

    // reset in the middle of a sweep, then a clean restart
    fm1[0] = 8'hC5; fm2[0] = 8'hC5;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if ({x_w[0], y_w[0], z_w[0]} == 3'd4) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    check("midsweep_idx4_reached", int'(reached), 1);
    do_reset();
    tick();
    sweep(0, 8'hC5, 8'hC5, 1'b0, edges);
    check("restart_latency", edges, 16);
    check("restart_tt1", int'(tt1_w[0]), 32'hC5);
    tick();

    // start re-pulsed while busy and during DONE
    sweep(0, 8'hC5, 8'hC5, 1'b1, edges);
    check("repulse_latency", edges, 16);
    check("repulse_tt1", int'(tt1_w[0]), 32'hC5);
    check("repulse_equal", int'(equal_w[0]), 1);
    check("repulse_match", int'(match_w[0]), 1);

    // start held high: back-to-back sweeps
    start_v[0] = 1'b1;
    for (int k = 0; k < 60; k++) tick();
    start_v[0] = 1'b0;
    for (int k = 0; k < 20; k++) tick();

    // randomized traffic on both DUTs
    for (int c = 0; c < 2000; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!act[d]) begin
          fm1[d] = 8'($urandom);
          fm2[d] = ($urandom_range(0, 1) == 0) ? fm1[d] : 8'($urandom);
        end
        start_v[d] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
